note_sequencer: RTL and testbench

- Parametrised successor to the single-buffer piano recorder.
- Records timed note events, each holding {octave, note, duration in ticks}, into a DEPTH-entry buffer.
- Plays events back with their recorded durations, optionally looping; supports append recording and explicit clear.
- Sits between the debounced input/octave logic and the amplifier; drives the amplifier's octave/note inputs.

---
 rtl/note_sequencer_if.sv | 36 +++
 rtl/note_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_note_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Bus between the live input/octave logic, the note sequencer and the amplifier.
// The master side drives commands and live notes; the slave side (the sequencer)
// returns the amplifier drive and status.
interface note_sequencer_if #(
    parameter int OCT_W  = 3,
    parameter int ADDR_W = 8
);
    logic              tick_en;
    logic [OCT_W-1:0]  octave_in;
    logic [2:0]        note_in;
    logic              cmd_rec;
    logic              cmd_play;
    logic              cmd_stop;
    logic              cmd_clear;
    logic              loop_en;

    logic [OCT_W-1:0]  octave_out;
    logic [2:0]        note_out;
    logic              recording;
    logic              playing;
    logic              full;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] play_idx;

    modport master (
        output tick_en, octave_in, note_in,
        output cmd_rec, cmd_play, cmd_stop, cmd_clear, loop_en,
        input  octave_out, note_out, recording, playing, full, count, play_idx
    );

    modport slave (
        input  tick_en, octave_in, note_in,
        input  cmd_rec, cmd_play, cmd_stop, cmd_clear, loop_en,
        output octave_out, note_out, recording, playing, full, count, play_idx
    );
endinterface

// File: rtl/note_sequencer.sv
// Timed note-event recorder/player. Stores {octave, note, duration} events in a
// DEPTH-entry RAM while recording and replays them with their durations, optionally
// looping. Outside playback the amplifier follows the live input with one clock delay.
//
// state | meaning
// IDLE  | monitor live input; accepts cmd_rec (not full) and cmd_play (count > 0)
// REC   | monitor live input; close an event on every note/octave change
// PLAY  | drive amplifier from the event RAM, one entry per recorded duration
module note_sequencer #(
    parameter int DEPTH = 256,
    parameter int OCT_W = 3,
    parameter int DUR_W = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    note_sequencer_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int ENT_W  = OCT_W + 3 + DUR_W;
    localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [DUR_W-1:0] DUR_MAX   = '1;
    localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  rd_data;
    logic [ENT_W-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;

    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_inc;
    logic              full;

    logic [OCT_W-1:0]  open_oct;
    logic [2:0]        open_note;
    logic [DUR_W-1:0]  dur;
    logic [DUR_W-1:0]  dur_tick;
    logic [DUR_W-1:0]  dur_close;
    logic              changed;

    logic [ADDR_W-1:0] play_idx;
    logic [ADDR_W-1:0] idx_inc;
    logic              last_entry;
    logic              loading;
    logic [DUR_W-1:0]  remain;
    logic              final_tick;

    logic [OCT_W-1:0]  rd_oct;
    logic [2:0]        rd_note;
    logic [DUR_W-1:0]  rd_dur;

    logic [OCT_W-1:0]  octave_q;
    logic [2:0]        note_q;

    logic              clear_buf;
    logic              rec_open;
    logic              play_start;
    logic              play_next;
    logic              play_wrap;
    logic              play_end;
    logic              play_abort;

    assign {rd_oct, rd_note, rd_dur} = rd_data;

    assign count_inc  = count + CNT_ONE;
    assign idx_inc    = play_idx + IDX_ONE;
    assign last_entry = (({1'b0, play_idx} + CNT_ONE) == count);

    // Duration including a tick that lands in the closing cycle; never stored as 0.
    assign dur_tick   = (bus.tick_en && (dur != DUR_MAX)) ? (dur + DUR_ONE) : dur;
    assign dur_close  = (dur_tick == '0) ? DUR_ONE : dur_tick;
    assign wr_data    = {open_oct, open_note, dur_close};
    assign changed    = ({bus.octave_in, bus.note_in} != {open_oct, open_note});

    // Ticks seen while the next entry is still being fetched are not counted.
    assign final_tick = !loading && bus.tick_en && (remain == DUR_ONE);

    // Next-state and control decode; command priority clear > stop > rec > play.
    always_comb begin
        state_nx   = state;
        wr_en      = 1'b0;
        rec_open   = 1'b0;
        clear_buf  = 1'b0;
        play_start = 1'b0;
        play_next  = 1'b0;
        play_wrap  = 1'b0;
        play_end   = 1'b0;
        play_abort = 1'b0;
        rd_addr    = play_idx;
        unique case (state)
            IDLE: begin
                if (bus.cmd_clear) begin
                    clear_buf = 1'b1;
                end else if (!bus.cmd_stop && bus.cmd_rec && !full) begin
                    state_nx = REC;
                    rec_open = 1'b1;
                end else if (!bus.cmd_stop && !bus.cmd_rec && bus.cmd_play && (count != '0)) begin
                    state_nx   = PLAY;
                    play_start = 1'b1;
                    rd_addr    = '0;
                end
            end
            REC: begin
                if (bus.cmd_clear) begin
                    clear_buf = 1'b1;
                    state_nx  = IDLE;
                end else if (bus.cmd_stop) begin
                    wr_en    = 1'b1;
                    state_nx = IDLE;
                end else if (changed) begin
                    wr_en    = 1'b1;
                    rec_open = 1'b1;
                    if (count_inc == DEPTH_CNT) begin
                        state_nx = IDLE;
                    end
                end
            end
            PLAY: begin
                if (bus.cmd_clear) begin
                    clear_buf  = 1'b1;
                    play_abort = 1'b1;
                    state_nx   = IDLE;
                end else if (bus.cmd_stop) begin
                    play_abort = 1'b1;
                    state_nx   = IDLE;
                end else if (final_tick) begin
                    if (!last_entry) begin
                        play_next = 1'b1;
                        rd_addr   = idx_inc;
                    end else if (bus.loop_en) begin
                        play_wrap = 1'b1;
                        rd_addr   = '0;
                    end else begin
                        play_end = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Stored event count and full flag; a write reaching DEPTH sets full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            full  <= 1'b0;
        end else if (clear_buf) begin
            count <= '0;
            full  <= 1'b0;
        end else if (wr_en) begin
            count <= count_inc;
            full  <= (count_inc == DEPTH_CNT);
        end
    end

    // Open event capture and saturating duration count while recording.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_oct  <= '0;
            open_note <= '0;
            dur       <= '0;
        end else if (rec_open) begin
            open_oct  <= bus.octave_in;
            open_note <= bus.note_in;
            dur       <= '0;
        end else if (state == REC) begin
            dur <= dur_tick;
        end
    end

    // Event RAM: write at the append index, registered read for playback.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[ADDR_W-1:0]] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    // Playback index, fetch phase and remaining-duration down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            play_idx <= '0;
            loading  <= 1'b0;
            remain   <= '0;
        end else if (play_start || play_wrap) begin
            play_idx <= '0;
            loading  <= 1'b1;
        end else if (play_next) begin
            play_idx <= idx_inc;
            loading  <= 1'b1;
        end else if (play_end || play_abort || clear_buf) begin
            play_idx <= '0;
            loading  <= 1'b0;
        end else if (state == PLAY) begin
            if (loading) begin
                remain  <= rd_dur;
                loading <= 1'b0;
            end else if (bus.tick_en) begin
                remain <= remain - DUR_ONE;
            end
        end
    end

    // Amplifier drive: live monitor outside PLAY, RAM entry during PLAY, silent on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            octave_q <= '0;
            note_q   <= '0;
        end else if (play_abort) begin
            octave_q <= '0;
            note_q   <= '0;
        end else if ((state == PLAY) && !play_end) begin
            if (loading) begin
                octave_q <= rd_oct;
                note_q   <= rd_note;
            end
        end else begin
            octave_q <= bus.octave_in;
            note_q   <= bus.note_in;
        end
    end

    assign bus.octave_out = octave_q;
    assign bus.note_out   = note_q;
    assign bus.recording  = (state == REC);
    assign bus.playing    = (state == PLAY);
    assign bus.full       = full;
    assign bus.count      = count;
    assign bus.play_idx   = play_idx;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a command/monitor vector table followed by
// hand-written record, playback, loop, saturation, full-buffer and reset sequences.
module tb_note_sequencer;
    localparam int OCT_W   = 3;
    localparam int DUR_W   = 12;
    localparam int DEPTH_A = 256;
    localparam int ADDR_A  = 8;
    localparam int DEPTH_B = 4;
    localparam int ADDR_B  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    note_sequencer_if #(.OCT_W(OCT_W), .ADDR_W(ADDR_A)) bus_a ();
    note_sequencer_if #(.OCT_W(OCT_W), .ADDR_W(ADDR_B)) bus_b ();

    note_sequencer #(.DEPTH(DEPTH_A), .OCT_W(OCT_W), .DUR_W(DUR_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    note_sequencer #(.DEPTH(DEPTH_B), .OCT_W(OCT_W), .DUR_W(DUR_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] oct;
        logic [2:0] note;
        logic       rec;
        logic       play;
        logic       stop;
        logic       clear;
        logic [2:0] exp_oct;
        logic [2:0] exp_note;
        logic       exp_rec;
        logic       exp_play;
        int         exp_count;
    } vec_t;

    typedef struct {
        logic [13:0] key;
        int          len;
    } seg_t;

    vec_t        vecs[8];
    logic [13:0] samp_q[$];
    seg_t        segs[$];
    seg_t        exp_segs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic rec, input logic play, input logic stop, input logic clear);
        bus_a.cmd_rec   = rec;
        bus_a.cmd_play  = play;
        bus_a.cmd_stop  = stop;
        bus_a.cmd_clear = clear;
        cyc();
        bus_a.cmd_rec   = 1'b0;
        bus_a.cmd_play  = 1'b0;
        bus_a.cmd_stop  = 1'b0;
        bus_a.cmd_clear = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus_a.tick_en = 1'b1;
            cyc();
            bus_a.tick_en = 1'b0;
            cyc();
        end
    endtask

    // Sample {play_idx, octave, note} on every tick, one tick every 4 clocks.
    task automatic collect(input int max_ticks);
        samp_q.delete();
        repeat (3) cyc();
        for (int t = 0; t < max_ticks; t++) begin
            if (bus_a.playing !== 1'b1) break;
            samp_q.push_back({bus_a.play_idx, bus_a.octave_out, bus_a.note_out});
            bus_a.tick_en = 1'b1;
            cyc();
            bus_a.tick_en = 1'b0;
            repeat (3) cyc();
        end
    endtask

    task automatic add_seg(input int idx, input int oct, input int note, input int len);
        seg_t s;
        s.key = {8'(idx), 3'(oct), 3'(note)};
        s.len = len;
        exp_segs.push_back(s);
    endtask

    task automatic compare_segs(input string tag);
        seg_t cur;
        int   n;
        segs.delete();
        foreach (samp_q[i]) begin
            if (segs.size() != 0 && segs[segs.size()-1].key == samp_q[i]) begin
                segs[segs.size()-1].len = segs[segs.size()-1].len + 1;
            end else begin
                cur.key = samp_q[i];
                cur.len = 1;
                segs.push_back(cur);
            end
        end
        check($sformatf("%s_nseg", tag), 32'(segs.size()), 32'(exp_segs.size()));
        n = (segs.size() < exp_segs.size()) ? segs.size() : exp_segs.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_key%0d", tag, i), 32'(segs[i].key), 32'(exp_segs[i].key));
            check($sformatf("%s_len%0d", tag, i), 32'(segs[i].len), 32'(exp_segs[i].len));
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.tick_en = 0; bus_a.octave_in = 0; bus_a.note_in = 0; bus_a.loop_en = 0;
        bus_a.cmd_rec = 0; bus_a.cmd_play = 0; bus_a.cmd_stop = 0; bus_a.cmd_clear = 0;
        bus_b.tick_en = 0; bus_b.octave_in = 0; bus_b.note_in = 0; bus_b.loop_en = 0;
        bus_b.cmd_rec = 0; bus_b.cmd_play = 0; bus_b.cmd_stop = 0; bus_b.cmd_clear = 0;

        //           oct   note  rec   play  stop  clr   e_oct e_note e_rec e_ply cnt
        vecs[0] = '{3'd2, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd5, 1'b0, 1'b0, 0};
        vecs[1] = '{3'd7, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 3'd0, 1'b0, 1'b0, 0};
        vecs[2] = '{3'd1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd3, 1'b0, 1'b0, 0};
        vecs[3] = '{3'd1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 3'd3, 1'b0, 1'b0, 0};
        vecs[4] = '{3'd6, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 3'd7, 1'b0, 1'b0, 0};
        vecs[5] = '{3'd4, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 3'd1, 1'b1, 1'b0, 0};
        vecs[6] = '{3'd4, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd1, 1'b1, 1'b0, 0};
        vecs[7] = '{3'd4, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 3'd1, 1'b1, 1'b0, 0};

        // Reset values
        repeat (3) cyc();
        check("rst_note", 32'(bus_a.note_out), 0);
        check("rst_oct", 32'(bus_a.octave_out), 0);
        check("rst_count", 32'(bus_a.count), 0);
        check("rst_full", 32'(bus_a.full), 0);
        check("rst_rec", 32'(bus_a.recording), 0);
        check("rst_play", 32'(bus_a.playing), 0);
        check("rst_idx", 32'(bus_a.play_idx), 0);
        rst_n = 1'b1;
        cyc();

        // Monitor path and command priority; ends with recording opened on {4,1}
        for (int i = 0; i < 8; i++) begin
            bus_a.octave_in = vecs[i].oct;
            bus_a.note_in   = vecs[i].note;
            pulse_a(vecs[i].rec, vecs[i].play, vecs[i].stop, vecs[i].clear);
            check($sformatf("vec%0d_oct", i), 32'(bus_a.octave_out), 32'(vecs[i].exp_oct));
            check($sformatf("vec%0d_note", i), 32'(bus_a.note_out), 32'(vecs[i].exp_note));
            check($sformatf("vec%0d_rec", i), 32'(bus_a.recording), 32'(vecs[i].exp_rec));
            check($sformatf("vec%0d_play", i), 32'(bus_a.playing), 32'(vecs[i].exp_play));
            check($sformatf("vec%0d_count", i), 32'(bus_a.count), 32'(vecs[i].exp_count));
        end

        // Record {4,1,10},{4,3,5},{4,0,2}
        tick_n(10);
        check("rec_hold_count", 32'(bus_a.count), 0);
        bus_a.note_in = 3'd3;
        cyc();
        check("rec_chg1_count", 32'(bus_a.count), 1);
        check("rec_chg1_rec", 32'(bus_a.recording), 1);
        tick_n(5);
        bus_a.note_in = 3'd0;
        cyc();
        check("rec_chg2_count", 32'(bus_a.count), 2);
        tick_n(2);
        pulse_a(1'b0, 1'b0, 1'b1, 1'b0);
        check("rec_stop_count", 32'(bus_a.count), 3);
        check("rec_stop_rec", 32'(bus_a.recording), 0);
        check("rec_stop_full", 32'(bus_a.full), 0);

        // Playback without loop
        bus_a.octave_in = 3'd2;
        bus_a.note_in   = 3'd6;
        bus_a.loop_en   = 1'b0;
        pulse_a(1'b0, 1'b1, 1'b0, 1'b0);
        check("play_started", 32'(bus_a.playing), 1);
        collect(30);
        exp_segs.delete();
        add_seg(0, 4, 1, 10);
        add_seg(1, 4, 3, 5);
        add_seg(2, 4, 0, 2);
        compare_segs("noloop");
        check("noloop_playing", 32'(bus_a.playing), 0);
        check("noloop_idx", 32'(bus_a.play_idx), 0);
        check("noloop_mon_note", 32'(bus_a.note_out), 6);
        check("noloop_mon_oct", 32'(bus_a.octave_out), 2);

        // Looping playback for 40 ticks, then stop
        bus_a.loop_en = 1'b1;
        pulse_a(1'b0, 1'b1, 1'b0, 1'b0);
        collect(40);
        exp_segs.delete();
        add_seg(0, 4, 1, 10);
        add_seg(1, 4, 3, 5);
        add_seg(2, 4, 0, 2);
        add_seg(0, 4, 1, 10);
        add_seg(1, 4, 3, 5);
        add_seg(2, 4, 0, 2);
        add_seg(0, 4, 1, 6);
        compare_segs("loop");
        check("loop_still_playing", 32'(bus_a.playing), 1);
        pulse_a(1'b0, 1'b0, 1'b1, 1'b0);
        check("loop_stop_playing", 32'(bus_a.playing), 0);
        check("loop_stop_note", 32'(bus_a.note_out), 0);
        check("loop_stop_oct", 32'(bus_a.octave_out), 0);
        cyc();
        check("loop_mon_note", 32'(bus_a.note_out), 6);
        check("loop_mon_oct", 32'(bus_a.octave_out), 2);
        bus_a.loop_en = 1'b0;

        // Clear beats play in the same cycle; play with empty buffer ignored
        pulse_a(1'b0, 1'b1, 1'b0, 1'b1);
        check("clrplay_count", 32'(bus_a.count), 0);
        check("clrplay_playing", 32'(bus_a.playing), 0);
        pulse_a(1'b0, 1'b1, 1'b0, 1'b0);
        check("empty_play_playing", 32'(bus_a.playing), 0);

        // Duration saturation and a sub-tick event
        bus_a.octave_in = 3'd3;
        bus_a.note_in   = 3'd5;
        pulse_a(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_rec", 32'(bus_a.recording), 1);
        bus_a.tick_en = 1'b1;
        repeat (5000) cyc();
        bus_a.tick_en = 1'b0;
        bus_a.note_in = 3'd2;
        cyc();
        bus_a.note_in = 3'd0;
        cyc();
        check("sat_chg_count", 32'(bus_a.count), 2);
        tick_n(3);
        pulse_a(1'b0, 1'b0, 1'b1, 1'b0);
        check("sat_stop_count", 32'(bus_a.count), 3);
        pulse_a(1'b0, 1'b1, 1'b0, 1'b0);
        collect(4200);
        exp_segs.delete();
        add_seg(0, 3, 5, 4095);
        add_seg(1, 3, 2, 1);
        add_seg(2, 3, 0, 3);
        compare_segs("sat");
        check("sat_end_playing", 32'(bus_a.playing), 0);

        // Asynchronous reset in the middle of playback
        pulse_a(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) cyc();
        check("mid_playing", 32'(bus_a.playing), 1);
        check("mid_note", 32'(bus_a.note_out), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_note", 32'(bus_a.note_out), 0);
        check("arst_oct", 32'(bus_a.octave_out), 0);
        check("arst_playing", 32'(bus_a.playing), 0);
        check("arst_count", 32'(bus_a.count), 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // DEPTH=4 instance: fill, ignore further record, clear
        bus_b.octave_in = 3'd1;
        bus_b.note_in   = 3'd1;
        bus_b.cmd_rec   = 1'b1;
        cyc();
        bus_b.cmd_rec   = 1'b0;
        check("b_rec", 32'(bus_b.recording), 1);
        for (int k = 2; k <= 7; k++) begin
            bus_b.note_in = 3'(k);
            cyc();
            check($sformatf("b_chg%0d_count", k), 32'(bus_b.count), 32'((k - 1 < 4) ? k - 1 : 4));
            check($sformatf("b_chg%0d_rec", k), 32'(bus_b.recording), 32'((k - 1 < 4) ? 1 : 0));
            check($sformatf("b_chg%0d_full", k), 32'(bus_b.full), 32'((k - 1 >= 4) ? 1 : 0));
        end
        bus_b.cmd_rec = 1'b1;
        cyc();
        bus_b.cmd_rec = 1'b0;
        check("b_full_rec_ignored", 32'(bus_b.recording), 0);
        check("b_full_count", 32'(bus_b.count), 4);
        bus_b.cmd_clear = 1'b1;
        cyc();
        bus_b.cmd_clear = 1'b0;
        check("b_clear_count", 32'(bus_b.count), 0);
        check("b_clear_full", 32'(bus_b.full), 0);
        bus_b.cmd_rec = 1'b1;
        cyc();
        bus_b.cmd_rec = 1'b0;
        check("b_rerec", 32'(bus_b.recording), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
